// File: rtl/sqrt_share_arbiter.sv
// Round-robin arbiter sharing one sequential 32->16 square-root core among NREQ requesters,
// with a START/FIN level handshake and a watchdog that aborts if the core never finishes.
module sqrt_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NREQ-1:0]      REQ,
  input  logic [32*NREQ-1:0]   X_IN,
  output logic [NREQ-1:0]      ACK,
  output logic [15:0]          RESULT,
  output logic [IDW-1:0]       RESULT_ID,
  output logic                 ERR,
  output logic                 BUSY,
  output logic                 SQ_START,
  output logic [31:0]          SQ_X,
  input  logic                 SQ_FIN,
  input  logic [15:0]          SQ_COUNT
);

  localparam int unsigned NR  = NREQ;
  localparam int          WDW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_FIN, DRAIN} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_gid;
  logic [WDW-1:0]   r_wd;
  logic [NREQ-1:0]  r_ack;
  logic [15:0]      r_result;
  logic [IDW-1:0]   r_rid;
  logic             r_err;
  logic             r_busy;
  logic             r_start;
  logic [31:0]      r_sq_x;

  logic             w_found;
  logic [IDW-1:0]   w_gnt;
  logic [IDW-1:0]   w_ptr_nxt;
  int unsigned      w_k;

  // Scan from the pointer upward, wrapping, so the last winner has lowest priority.
  always_comb begin
    w_found   = 1'b0;
    w_gnt     = '0;
    w_k       = 0;
    for (int unsigned i = 0; i < NR; i++) begin
      w_k = (int'(r_ptr) + i) % NR;
      if (!w_found && REQ[w_k]) begin
        w_found = 1'b1;
        w_gnt   = IDW'(w_k);
      end
    end
    w_ptr_nxt = IDW'((int'(w_gnt) + 1) % NR);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_gid    <= '0;
      r_wd     <= '0;
      r_ack    <= '0;
      r_result <= '0;
      r_rid    <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_start  <= 1'b0;
      r_sq_x   <= '0;
    end else begin
      r_ack <= '0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!SQ_FIN && w_found) begin
            r_sq_x  <= X_IN[32*w_gnt +: 32];
            r_start <= 1'b1;
            r_gid   <= w_gnt;
            r_ptr   <= w_ptr_nxt;
            r_wd    <= '0;
            r_busy  <= 1'b1;
            r_state <= WAIT_FIN;
          end
        end
        WAIT_FIN: begin
          if (SQ_FIN) begin
            r_result <= SQ_COUNT;
            r_rid    <= r_gid;
            r_ack    <= NREQ'(1) << r_gid;
            r_start  <= 1'b0;
            r_state  <= DRAIN;
          end else if (r_wd == WDW'(TIMEOUT - 1)) begin
            r_result <= '0;
            r_rid    <= r_gid;
            r_ack    <= NREQ'(1) << r_gid;
            r_err    <= 1'b1;
            r_start  <= 1'b0;
            r_state  <= DRAIN;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        DRAIN: begin
          // Hold off until the core has dropped FIN, i.e. it is back in its own idle.
          if (!SQ_FIN) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_start <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ACK       = r_ack;
  assign RESULT    = r_result;
  assign RESULT_ID = r_rid;
  assign ERR       = r_err;
  assign BUSY      = r_busy;
  assign SQ_START  = r_start;
  assign SQ_X      = r_sq_x;

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// Directed bench for sqrt_share_arbiter with a behavioural 16-iteration square-root core.
module tb_sqrt_share_arbiter;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [3:0]   REQ;
  logic [127:0] X_IN;
  logic [3:0]   ACK;
  logic [15:0]  RESULT;
  logic [1:0]   RESULT_ID;
  logic         ERR;
  logic         BUSY;
  logic         SQ_START;
  logic [31:0]  SQ_X;
  logic         sq_fin;
  logic [15:0]  sq_count;
  logic [4:0]   c_cnt;
  logic         stuck;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  sqrt_share_arbiter #(.NREQ(4), .TIMEOUT(64)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .X_IN(X_IN),
    .ACK(ACK), .RESULT(RESULT), .RESULT_ID(RESULT_ID), .ERR(ERR), .BUSY(BUSY),
    .SQ_START(SQ_START), .SQ_X(SQ_X), .SQ_FIN(sq_fin), .SQ_COUNT(sq_count)
  );

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if ({32'd0, t} * {32'd0, t} <= {32'd0, x}) r = t;
    end
    return r;
  endfunction

  // Core model: FIN rises after 17 cycles of START and holds until START drops.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sq_fin   <= 1'b0;
      c_cnt    <= '0;
      sq_count <= '0;
    end else if (stuck || !SQ_START) begin
      sq_fin <= 1'b0;
      c_cnt  <= '0;
    end else if (!sq_fin) begin
      c_cnt <= c_cnt + 1'b1;
      if (c_cnt == 5'd16) begin
        sq_fin   <= 1'b1;
        sq_count <= isqrt(SQ_X);
      end
    end
  end

  task automatic step_to_ack(input int limit, output int cyc, output logic [3:0] seen);
    cyc  = 0;
    seen = '0;
    while (cyc < limit && seen == 4'b0) begin
      @(posedge CLK); #1;
      cyc++;
      if (ACK != 4'b0) begin
        seen = ACK;
        REQ  = REQ & ~ACK;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (BUSY && n < 10) begin
      @(posedge CLK); #1;
      n++;
    end
    total++;
    if (BUSY !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: BUSY=%b required 0", name, BUSY);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; REQ = '0; X_IN = '0; stuck = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total++; if (ACK !== 4'b0)       begin bad++; $display("FAIL rst_ack: got %b required 0000", ACK); end
    total++; if (RESULT !== 16'h0)   begin bad++; $display("FAIL rst_result: got %h required 0000", RESULT); end
    total++; if (RESULT_ID !== 2'd0) begin bad++; $display("FAIL rst_id: got %0d required 0", RESULT_ID); end
    total++; if (ERR !== 1'b0)       begin bad++; $display("FAIL rst_err: got %b required 0", ERR); end
    total++; if (BUSY !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b required 0", BUSY); end
    total++; if (SQ_START !== 1'b0)  begin bad++; $display("FAIL rst_start: got %b required 0", SQ_START); end
    total++; if (SQ_X !== 32'h0)     begin bad++; $display("FAIL rst_sqx: got %h required 0", SQ_X); end
    RESET = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp_r [4];
    int cyc;
    logic [3:0] seen;
    exp_r[0] = 16'd12; exp_r[1] = 16'hFFFF; exp_r[2] = 16'd1; exp_r[3] = 16'd0;
    X_IN[31:0]   = 32'd144;
    X_IN[63:32]  = 32'hFFFF_FFFF;
    X_IN[95:64]  = 32'd2;
    X_IN[127:96] = 32'd0;
    REQ = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step_to_ack(40, cyc, seen);
      total++;
      if (seen !== (4'b0001 << i)) begin bad++; $display("FAIL sim_ack%0d: got %b required %b", i, seen, 4'b0001 << i); end
      total++;
      if (cyc != ((i == 0) ? 19 : 21)) begin bad++; $display("FAIL sim_spacing%0d: got %0d required %0d", i, cyc, (i == 0) ? 19 : 21); end
      total++;
      if (RESULT !== exp_r[i] || RESULT_ID !== 2'(i) || ERR !== 1'b0) begin
        bad++;
        $display("FAIL sim_result%0d: got %h id %0d err %b required %h id %0d err 0", i, RESULT, RESULT_ID, ERR, exp_r[i], i);
      end
    end
    wait_idle("sim");
  endtask

  task automatic test_single();
    logic ack_bad;
    ack_bad = 1'b0;
    X_IN[95:64] = 32'd1000000;
    REQ = 4'b0100;
    for (int n = 1; n <= 21; n++) begin
      @(posedge CLK); #1;
      if (n == 1) begin
        total++;
        if (SQ_START !== 1'b1 || BUSY !== 1'b1 || SQ_X !== 32'd1000000) begin
          bad++; $display("FAIL single_start: start %b busy %b x %0d required 1 1 1000000", SQ_START, BUSY, SQ_X);
        end
      end
      if (n == 19) begin
        total++;
        if (ACK !== 4'b0100 || RESULT !== 16'h03E8 || RESULT_ID !== 2'd2 || ERR !== 1'b0) begin
          bad++; $display("FAIL single_ack: ack %b res %h id %0d err %b required 0100 03e8 2 0", ACK, RESULT, RESULT_ID, ERR);
        end
        REQ = REQ & ~ACK;
      end else if (ACK !== 4'b0) ack_bad = 1'b1;
      if (n == 20) begin
        total++;
        if (BUSY !== 1'b1 || RESULT !== 16'h03E8) begin bad++; $display("FAIL single_drain: busy %b res %h required 1 03e8", BUSY, RESULT); end
      end
      if (n == 21) begin
        total++;
        if (BUSY !== 1'b0) begin bad++; $display("FAIL single_busy21: got %b required 0", BUSY); end
      end
    end
    total++;
    if (ack_bad) begin bad++; $display("FAIL single_stray_ack: got stray ACK required none outside cycle 19"); end
    REQ = '0;
  endtask

  task automatic test_round_robin();
    int cyc;
    logic [3:0] seen;
    X_IN[63:32] = 32'd81; X_IN[31:0] = 32'd25; X_IN[127:96] = 32'd36;
    REQ = 4'b0010;
    step_to_ack(40, cyc, seen);
    total++;
    if (seen !== 4'b0010 || RESULT !== 16'd9) begin bad++; $display("FAIL rr_first: ack %b res %0d required 0010 9", seen, RESULT); end
    wait_idle("rr1");
    REQ = 4'b1001;
    step_to_ack(40, cyc, seen);
    total++;
    if (seen !== 4'b1000 || RESULT !== 16'd6 || RESULT_ID !== 2'd3) begin bad++; $display("FAIL rr_three: ack %b res %0d id %0d required 1000 6 3", seen, RESULT, RESULT_ID); end
    step_to_ack(40, cyc, seen);
    total++;
    if (seen !== 4'b0001 || RESULT !== 16'd5 || RESULT_ID !== 2'd0) begin bad++; $display("FAIL rr_zero: ack %b res %0d id %0d required 0001 5 0", seen, RESULT, RESULT_ID); end
    wait_idle("rr2");
  endtask

  task automatic test_freeze();
    logic x_bad;
    int n;
    x_bad = 1'b0;
    n = 0;
    X_IN[31:0] = 32'd144;
    REQ = 4'b0001;
    while (ACK == 4'b0 && n < 40) begin
      @(posedge CLK); #1;
      n++;
      if (n == 2) X_IN[31:0] = 32'd400;
      if (SQ_START && SQ_X !== 32'd144) x_bad = 1'b1;
    end
    REQ = REQ & ~ACK;
    total++;
    if (x_bad) begin bad++; $display("FAIL freeze_sqx: SQ_X changed while START high, required 144"); end
    total++;
    if (ACK !== 4'b0001 || RESULT !== 16'd12) begin bad++; $display("FAIL freeze_result: ack %b res %0d required 0001 12", ACK, RESULT); end
    wait_idle("freeze");
  endtask

  task automatic test_timeout();
    int cyc;
    logic [3:0] seen;
    stuck = 1'b1;
    X_IN[63:32] = 32'd10000;
    REQ = 4'b0010;
    step_to_ack(100, cyc, seen);
    total++;
    if (seen !== 4'b0010 || cyc != 65) begin bad++; $display("FAIL tmo_ack: ack %b at cycle %0d required 0010 at 65", seen, cyc); end
    total++;
    if (ERR !== 1'b1 || RESULT !== 16'h0 || SQ_START !== 1'b0 || RESULT_ID !== 2'd1) begin
      bad++; $display("FAIL tmo_err: err %b res %h start %b id %0d required 1 0000 0 1", ERR, RESULT, SQ_START, RESULT_ID);
    end
    @(posedge CLK); #1;
    total++;
    if (ERR !== 1'b0 || ACK !== 4'b0) begin bad++; $display("FAIL tmo_pulse: err %b ack %b required 0 0000", ERR, ACK); end
    stuck = 1'b0;
    wait_idle("tmo");
    X_IN[127:96] = 32'd49;
    REQ = 4'b1000;
    step_to_ack(40, cyc, seen);
    total++;
    if (seen !== 4'b1000 || cyc != 19 || RESULT !== 16'd7 || ERR !== 1'b0) begin
      bad++; $display("FAIL tmo_recover: ack %b cyc %0d res %0d err %b required 1000 19 7 0", seen, cyc, RESULT, ERR);
    end
    wait_idle("tmo2");
  endtask

  task automatic test_reset_midop();
    int cyc;
    logic [3:0] seen;
    logic ack_bad;
    ack_bad = 1'b0;
    X_IN[95:64] = 32'd10000;
    REQ = 4'b0100;
    repeat (10) begin
      @(posedge CLK); #1;
      if (ACK !== 4'b0) ack_bad = 1'b1;
    end
    RESET = 1'b0;
    #1;
    total++;
    if (ACK !== 4'b0 || RESULT !== 16'h0 || RESULT_ID !== 2'd0 || ERR !== 1'b0 ||
        BUSY !== 1'b0 || SQ_START !== 1'b0 || SQ_X !== 32'h0) begin
      bad++;
      $display("FAIL midrst_outputs: ack %b res %h id %0d err %b busy %b start %b x %h required all 0",
               ACK, RESULT, RESULT_ID, ERR, BUSY, SQ_START, SQ_X);
    end
    REQ = '0;
    repeat (2) begin
      @(posedge CLK); #1;
      if (ACK !== 4'b0) ack_bad = 1'b1;
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    if (ACK !== 4'b0) ack_bad = 1'b1;
    total++;
    if (ack_bad) begin bad++; $display("FAIL midrst_noack: ACK seen around reset, required none"); end
    REQ = 4'b0100;
    step_to_ack(40, cyc, seen);
    total++;
    if (seen !== 4'b0100 || cyc != 19 || RESULT !== 16'd100 || RESULT_ID !== 2'd2) begin
      bad++; $display("FAIL midrst_fresh: ack %b cyc %0d res %0d id %0d required 0100 19 100 2", seen, cyc, RESULT, RESULT_ID);
    end
    wait_idle("midrst");
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_single();
    test_round_robin();
    test_freeze();
    test_timeout();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sqrt_share_arbiter.md
Name: sqrt_share_arbiter

Overview:
- Shares one 32->16 sequential square-root core among NREQ requesters, for example magnitude computations from several acquisition channels.
- Per requester, the block arbitrates REQ lines round-robin and latches the granted operand. It then sequences the core through its START/FIN level handshake and returns the result with a one-cycle ACK.
- A watchdog aborts the operation if the core never asserts FIN.

Parameters:
NREQ, 4, number of requesters (2..16); ID width is clog2(NREQ).
TIMEOUT, 64, maximum cycles START may stay high without FIN before abort (must be > 18).

Ports:
CLK  in  1  clock.
RESET  in  1  asynchronous, active-low reset.
REQ  in  NREQ  per-requester level request; held high until its ACK.
X_IN  in  32*NREQ  operands, flattened; requester i uses bits [32i+31:32i]; stable while REQ[i] is high.
ACK  out  NREQ  one-hot, one-cycle completion pulse.
RESULT  out  16  last square root; valid in the ACK cycle, held until the next ACK.
RESULT_ID  out  clog2(NREQ)  index of the requester that RESULT belongs to.
ERR  out  1  one-cycle pulse coincident with ACK when the operation timed out.
BUSY  out  1  high in every state except IDLE.
SQ_START  out  1  to core START.
SQ_X  out  32  to core X.
SQ_FIN  in  1  from core FIN.
SQ_COUNT  in  16  from core COUNT.

Behaviour:
- Reset (async, RESET=0): state IDLE. ACK, RESULT, RESULT_ID, ERR, SQ_START, SQ_X and BUSY are all 0. Round-robin pointer is 0 and the watchdog counter is 0. Reset mid-operation aborts immediately without an ACK; the core shares RESET.
- All outputs are registered.
- States: IDLE, WAIT_FIN, DRAIN.
- IDLE:
  - Applies only if SQ_FIN=0 and REQ is nonzero.
  - Winner g = first set REQ bit scanning g = ptr, ptr+1, ... mod NREQ.
  - At the next edge: SQ_X <= X_IN[g], SQ_START <= 1, grant index stored, ptr <= (g+1) mod NREQ, watchdog cleared, go to WAIT_FIN.
  - If SQ_FIN=1, IDLE waits and grants nothing.
- WAIT_FIN:
  - SQ_START is held at 1 and SQ_X stays frozen; later X_IN changes are ignored. The watchdog increments every cycle.
  - On SQ_FIN=1: RESULT <= SQ_COUNT, RESULT_ID <= g, ACK[g] <= 1, SQ_START <= 0, go to DRAIN.
  - Else, when watchdog reaches TIMEOUT-1: RESULT <= 16'h0000, RESULT_ID <= g, ACK[g] <= 1, ERR <= 1, SQ_START <= 0, go to DRAIN.
- DRAIN:
  - ACK and ERR return to 0 after one cycle.
  - Stays in DRAIN until SQ_FIN=0, then goes to IDLE. This prevents restarting the core before it has re-entered idle.
- Latency with the team's 16-iteration core:
  - REQ seen in IDLE in cycle 0; SQ_START high in cycle 1.
  - Core FIN high in cycle 18; ACK high in cycle 19.
  - DRAIN exits at the cycle-20 edge; IDLE in cycle 21; next SQ_START earliest in cycle 22.
  - Throughput is one operation per 21 cycles.
- Requester protocol:
  - A requester clears REQ at the edge where it samples ACK=1, so its REQ is 0 once the arbiter is back in IDLE.
  - Dropping REQ early does not cancel a granted operation; ACK is still pulsed.
  - REQ bits that are not granted are untouched and wait in arbitration.
- Fairness: after a grant to g, g has lowest priority. With all REQ bits high, grants rotate 0,1,...,NREQ-1,0,...
- RESULT is floor(sqrt(X)), as computed by the core; the arbiter performs no arithmetic.

Test Plan:
- Single request: REQ[2]=1, X_IN[2]=1000000. Expect ACK=4'b0100 in cycle 19, RESULT=1000 (0x03E8), RESULT_ID=2, ERR=0, BUSY low again in cycle 21.
- Simultaneous: all REQ high with X = 144, 0xFFFFFFFF, 2, 0. Expect ACKs in order 0,1,2,3 with RESULT = 12, 0xFFFF, 1, 0, spaced 21 cycles apart.
- Round-robin pointer: after a grant to 1, assert REQ[0] and REQ[3] together. Expect 3 granted before 0.
- Operand freeze: change X_IN[0] from 144 to 400 one cycle after SQ_START rises. Expect RESULT=12 and SQ_X constant at 144 throughout.
- Timeout: replace the core with a stub holding SQ_FIN=0, TIMEOUT=64. Expect ACK[g] and ERR together 64 cycles after SQ_START rises, RESULT=0, SQ_START=0. The next request must proceed normally.
- Reset mid-operation: drop RESET in cycle 10 of an operation. Expect all outputs 0 immediately and no ACK. After release, a fresh REQ completes with the correct result.
